// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
//   Shared types and constants for the register-file writeback scheduler.
//   DW    : register data width
//   AW    : register address width
//   NREG  : number of architectural registers (2**AW)
//   wb_req_t : one queued writeback request {addr, data}
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// ----------------------------------------------------------------------------
// rf_wb_fifo
//   Synchronous FIFO of wb_req_t used to park long-latency results until the
//   register file write port is free.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     i_push     : enqueue i_data (ignored while full)
//     i_data     : request to enqueue
//     i_pop      : dequeue head (ignored while empty)
//     o_head     : current head entry (valid when !o_empty)
//     o_full     : DEPTH entries held
//     o_empty    : no entries held
//   Push and pop in the same cycle are allowed whenever the FIFO is not full;
//   a full FIFO never accepts a push, even if it is popping that cycle.
// ----------------------------------------------------------------------------
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t        r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic           w_push;
    logic           w_pop;

    // Wrap explicitly so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rptr];

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// ----------------------------------------------------------------------------
// rf_wb_scheduler
//   Owner of the single register-file write port. The in-order pipe writeback
//   always wins; long-latency results (mul/div, miss loads) are queued and
//   drained whenever the pipe is not writing. A per-register busy scoreboard
//   tracks destinations of outstanding long ops and stalls issue on RAW/WAW.
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     i_iss_valid         : instruction presented at issue
//     i_iss_long          : instruction is long-latency
//     i_iss_rd_we         : instruction writes i_iss_rd
//     i_iss_rs/rt/rd      : source 1 / source 2 / destination registers
//     o_iss_stall         : hold issue this cycle
//     i_pipe_we/waddr/wdata : pipe writeback request
//     i_lu_valid/waddr/wdata : long-unit result
//     o_lu_ready          : result FIFO can accept
//     o_wb_hold           : registered; pipe must suppress writes while high
//     o_rf_we/waddr/wdata : register file write port
//     o_busy_vec          : scoreboard contents
//     o_ovf_err           : sticky, long result arrived while FIFO full
// ----------------------------------------------------------------------------
module rf_wb_scheduler
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_iss_valid,
    input  logic            i_iss_long,
    input  logic            i_iss_rd_we,
    input  logic [AW-1:0]   i_iss_rs,
    input  logic [AW-1:0]   i_iss_rt,
    input  logic [AW-1:0]   i_iss_rd,
    output logic            o_iss_stall,
    input  logic            i_pipe_we,
    input  logic [AW-1:0]   i_pipe_waddr,
    input  logic [DW-1:0]   i_pipe_wdata,
    input  logic            i_lu_valid,
    output logic            o_lu_ready,
    input  logic [AW-1:0]   i_lu_waddr,
    input  logic [DW-1:0]   i_lu_wdata,
    output logic            o_wb_hold,
    output logic            o_rf_we,
    output logic [AW-1:0]   o_rf_waddr,
    output logic [DW-1:0]   o_rf_wdata,
    output logic [NREG-1:0] o_busy_vec,
    output logic            o_ovf_err
);

    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned GW = $clog2(STARVE_LIMIT + 1);

    logic [NREG-1:0] r_busy;
    logic [OW-1:0]   r_outst;
    logic [GW-1:0]   r_age;
    logic            r_wb_hold;
    logic            r_ovf;

    logic [NREG-1:0] w_busy_nxt;
    logic [OW-1:0]   w_outst_nxt;
    logic [GW-1:0]   w_age_nxt;

    logic            w_pipe_we;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_push;
    logic            w_pop;
    wb_req_t         w_head;
    wb_req_t         w_lu_req;
    logic            w_stall;
    logic            w_accept;
    logic            w_long_acc;

    // ------------------------------------------------------------------
    // Long-result queue
    // ------------------------------------------------------------------
    assign w_push   = i_lu_valid & ~w_fifo_full;
    assign w_lu_req = '{addr: i_lu_waddr, data: i_lu_wdata};

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_lu_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_lu_ready = ~w_fifo_full;

    // ------------------------------------------------------------------
    // Write-port mux: pipe has fixed priority, queue head fills idle slots.
    // The whole port is quiet while reset is asserted.
    // ------------------------------------------------------------------
    assign w_pipe_we = i_pipe_we & rst_n;

    always_comb begin
        o_rf_we    = 1'b0;
        o_rf_waddr = '0;
        o_rf_wdata = '0;
        w_pop      = 1'b0;
        if (w_pipe_we) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = i_pipe_waddr;
            o_rf_wdata = i_pipe_wdata;
        end else if (rst_n && !w_fifo_empty) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = w_head.addr;
            o_rf_wdata = w_head.data;
            w_pop      = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue hazard check. Uses registered state only, so a result that is
    // draining this cycle still blocks its dependants until the next one.
    // rs/rt are checked even if the instruction does not read them.
    // ------------------------------------------------------------------
    assign w_stall = i_iss_valid &
                     (r_busy[i_iss_rs] | r_busy[i_iss_rt] |
                      (i_iss_rd_we & r_busy[i_iss_rd]) |
                      (i_iss_long & (r_outst == OW'(DEPTH))));

    assign w_accept    = i_iss_valid & ~w_stall;
    assign w_long_acc  = w_accept & i_iss_long;
    assign o_iss_stall = w_stall;

    // Scoreboard: the WAW stall guarantees a set and a clear never target the
    // same live entry, so their order here is immaterial.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head.addr] = 1'b0;
        end
        if (w_long_acc && i_iss_rd_we && (i_iss_rd != '0)) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Outstanding long ops, including those with rd=0 or no destination.
    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_long_acc, w_pop})
            2'b10: begin
                if (r_outst != OW'(DEPTH)) begin
                    w_outst_nxt = r_outst + OW'(1);
                end
            end
            2'b01: begin
                if (r_outst != '0) begin
                    w_outst_nxt = r_outst - OW'(1);
                end
            end
            default: w_outst_nxt = r_outst;
        endcase
    end

    // Starvation age: counts cycles the queue head is blocked by the pipe.
    always_comb begin
        w_age_nxt = '0;
        if (!w_fifo_empty && w_pipe_we) begin
            w_age_nxt = (r_age == GW'(STARVE_LIMIT)) ? r_age : r_age + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_outst   <= '0;
            r_age     <= '0;
            r_wb_hold <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_outst   <= w_outst_nxt;
            r_age     <= w_age_nxt;
            r_wb_hold <= (w_age_nxt == GW'(STARVE_LIMIT));
            r_ovf     <= r_ovf | (i_lu_valid & w_fifo_full);
        end
    end

    assign o_busy_vec = r_busy;
    assign o_wb_hold  = r_wb_hold;
    assign o_ovf_err  = r_ovf;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios followed by a
// randomized phase, all checked every cycle against a queue-based model.
module tb_rf_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        iss_valid, iss_long, iss_rd_we;
    logic [4:0]  iss_rs, iss_rt, iss_rd;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;

    logic        o_iss_stall, o_lu_ready, o_wb_hold, o_rf_we, o_ovf_err;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic [31:0] o_busy_vec;

    rf_wb_scheduler #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_iss_valid  (iss_valid),
        .i_iss_long   (iss_long),
        .i_iss_rd_we  (iss_rd_we),
        .i_iss_rs     (iss_rs),
        .i_iss_rt     (iss_rt),
        .i_iss_rd     (iss_rd),
        .o_iss_stall  (o_iss_stall),
        .i_pipe_we    (pipe_we),
        .i_pipe_waddr (pipe_waddr),
        .i_pipe_wdata (pipe_wdata),
        .i_lu_valid   (lu_valid),
        .o_lu_ready   (o_lu_ready),
        .i_lu_waddr   (lu_waddr),
        .i_lu_wdata   (lu_wdata),
        .o_wb_hold    (o_wb_hold),
        .o_rf_we      (o_rf_we),
        .o_rf_waddr   (o_rf_waddr),
        .o_rf_wdata   (o_rf_wdata),
        .o_busy_vec   (o_busy_vec),
        .o_ovf_err    (o_ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t       m_q[$];     // queued long results
    logic [4:0] m_pend[$];  // accepted long ops still awaiting a result
    bit [31:0]  m_busy;
    int         m_outst;
    int         m_age;
    bit         m_hold;
    bit         m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend.delete();
        m_busy  = '0;
        m_outst = 0;
        m_age   = 0;
        m_hold  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic idle();
        iss_valid  = 1'b0;
        iss_long   = 1'b0;
        iss_rd_we  = 1'b0;
        iss_rs     = '0;
        iss_rt     = '0;
        iss_rd     = '0;
        pipe_we    = 1'b0;
        pipe_waddr = '0;
        pipe_wdata = '0;
        lu_valid   = 1'b0;
        lu_waddr   = '0;
        lu_wdata   = '0;
    endtask

    task automatic issue(input bit lng, input bit we, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_long  = lng;
        iss_rd_we = we;
        iss_rs    = rs;
        iss_rt    = rt;
        iss_rd    = rd;
    endtask

    // One clock: check every output against the model, clock, update model.
    task automatic cycle(input string tag);
        bit   e_stall, e_ready, pop, blocked;
        ent_t h;
        #2;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            model_reset();
            return;
        end
        e_stall = iss_valid && (m_busy[iss_rs] || m_busy[iss_rt] ||
                  (iss_rd_we && m_busy[iss_rd]) || (iss_long && m_outst == 4));
        e_ready = m_q.size() < 4;
        blocked = (m_q.size() > 0) && pipe_we;
        pop     = 1'b0;
        chk({tag, ":stall"}, o_iss_stall, e_stall);
        chk({tag, ":ready"}, o_lu_ready, e_ready);
        chk({tag, ":busy"},  o_busy_vec, m_busy);
        chk({tag, ":hold"},  o_wb_hold, m_hold);
        chk({tag, ":ovf"},   o_ovf_err, m_ovf);
        if (pipe_we) begin
            chk({tag, ":we"},    o_rf_we, 1);
            chk({tag, ":waddr"}, o_rf_waddr, pipe_waddr);
            chk({tag, ":wdata"}, o_rf_wdata, pipe_wdata);
        end else if (m_q.size() > 0) begin
            h   = m_q[0];
            pop = 1'b1;
            chk({tag, ":we"},    o_rf_we, 1);
            chk({tag, ":waddr"}, o_rf_waddr, h.a);
            chk({tag, ":wdata"}, o_rf_wdata, h.d);
        end else begin
            chk({tag, ":we"}, o_rf_we, 0);
        end
        @(posedge clk);
        #1;
        m_age  = blocked ? ((m_age < 8) ? m_age + 1 : 8) : 0;
        m_hold = (m_age == 8);
        if (pop) begin
            void'(m_q.pop_front());
            m_busy[h.a] = 1'b0;
            if (m_outst > 0) m_outst--;
        end
        if (lu_valid) begin
            if (e_ready) m_q.push_back('{a: lu_waddr, d: lu_wdata});
            else         m_ovf = 1'b1;
        end
        if (iss_valid && !e_stall && iss_long) begin
            m_outst++;
            if (iss_rd_we && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            m_pend.push_back(iss_rd_we ? iss_rd : 5'd0);
        end
        m_busy[0] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;

        // Reset
        cycle("rst0");
        cycle("rst1");
        rst_n = 1'b1;
        #1;
        chk("rst_rf_we", o_rf_we, 0);
        chk("rst_busy", o_busy_vec, 0);
        chk("rst_ready", o_lu_ready, 1);
        chk("rst_stall", o_iss_stall, 0);
        chk("rst_hold", o_wb_hold, 0);
        chk("rst_ovf", o_ovf_err, 0);
        cycle("post_rst");

        // RAW on a long destination, released two cycles after the result
        issue(1, 1, 5'd1, 5'd2, 5'd5);
        cycle("raw_long5");
        issue(0, 1, 5'd5, 5'd0, 5'd9);
        #1 chk("raw_stall0", o_iss_stall, 1);
        cycle("raw_a");
        lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
        #1 chk("raw_stall1", o_iss_stall, 1);
        cycle("raw_lu");
        lu_valid = 1'b0;
        #1;
        chk("raw_drain_we", o_rf_we, 1);
        chk("raw_drain_addr", o_rf_waddr, 5);
        chk("raw_drain_data", o_rf_wdata, 32'hDEADBEEF);
        chk("raw_stall2", o_iss_stall, 1);
        cycle("raw_drain");
        #1;
        chk("raw_busy5_clr", o_busy_vec[5], 0);
        chk("raw_released", o_iss_stall, 0);
        cycle("raw_accept");
        idle();

        // Pipe priority and starvation hold
        issue(1, 1, 5'd0, 5'd0, 5'd7);
        cycle("st_long7");
        idle();
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
        cycle("st_lu7");
        lu_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            pipe_we    = 1'b1;
            pipe_waddr = 5'd3;
            pipe_wdata = (k == 1) ? 32'h11 : 32'(k);
            #1;
            if (k == 1) begin
                chk("st_pipe_first_addr", o_rf_waddr, 3);
                chk("st_pipe_first_data", o_rf_wdata, 32'h11);
            end
            chk($sformatf("st_hold_k%0d", k), o_wb_hold, (k >= 9));
            cycle($sformatf("st_blk%0d", k));
        end
        pipe_we = 1'b0;
        #1;
        chk("st_r7_we", o_rf_we, 1);
        chk("st_r7_addr", o_rf_waddr, 7);
        chk("st_r7_data", o_rf_wdata, 32'h77);
        chk("st_hold_still", o_wb_hold, 1);
        cycle("st_drain");
        #1 chk("st_hold_fall", o_wb_hold, 0);
        cycle("st_after");

        // Outstanding limit
        for (int i = 1; i <= 4; i++) begin
            issue(1, 1, 5'd0, 5'd0, 5'(i));
            #1 chk($sformatf("lim_acc%0d", i), o_iss_stall, 0);
            cycle($sformatf("lim_iss%0d", i));
        end
        issue(1, 1, 5'd0, 5'd0, 5'd6);
        #1 chk("lim_full_stall", o_iss_stall, 1);
        cycle("lim_r6a");
        lu_valid = 1'b1; lu_waddr = 5'd1; lu_wdata = 32'h1001;
        #1 chk("lim_stall_lu", o_iss_stall, 1);
        cycle("lim_lu1");
        lu_valid = 1'b0;
        #1;
        chk("lim_drain_addr", o_rf_waddr, 1);
        chk("lim_stall_drain", o_iss_stall, 1);
        cycle("lim_drain");
        #1 chk("lim_r6_accept", o_iss_stall, 0);
        cycle("lim_r6b");
        idle();
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1;
            lu_waddr = (i == 3) ? 5'd6 : 5'(i + 2);
            lu_wdata = $urandom;
            cycle($sformatf("lim_res%0d", i));
        end
        idle();
        for (int i = 0; i < 3; i++) cycle("lim_idle");

        // Long op to r0 and overflow
        issue(1, 1, 5'd0, 5'd0, 5'd0);
        cycle("r0_long");
        idle();
        #1 chk("r0_busy", o_busy_vec, 0);
        issue(0, 1, 5'd0, 5'd0, 5'd0);
        #1 chk("r0_read_nostall", o_iss_stall, 0);
        cycle("r0_read");
        for (int i = 1; i <= 3; i++) begin
            issue(1, 1, 5'd0, 5'd0, 5'(i));
            cycle("ovf_iss");
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = $urandom;
            lu_valid = 1'b1; lu_waddr = 5'(i); lu_wdata = 32'hA0 + 32'(i);
            cycle("ovf_fill");
        end
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'hBAD;
        #1 chk("ovf_not_ready", o_lu_ready, 0);
        cycle("ovf_drop");
        lu_valid = 1'b0;
        #1 chk("ovf_set", o_ovf_err, 1);
        pipe_we = 1'b0;
        for (int i = 0; i < 6; i++) cycle("ovf_drain");
        chk("ovf_sticky", o_ovf_err, 1);

        // Randomized traffic
        m_pend.delete();
        for (int c = 0; c < 400; c++) begin
            iss_valid = ($urandom % 10) < 6;
            iss_long  = ($urandom % 10) < 3;
            iss_rd_we = ($urandom % 10) < 8;
            iss_rs    = 5'($urandom_range(0, 7));
            iss_rt    = 5'($urandom_range(0, 7));
            iss_rd    = 5'($urandom_range(0, 7));
            pipe_we   = m_hold ? (($urandom % 8) == 0) : 1'($urandom % 2);
            pipe_waddr = 5'($urandom);
            pipe_wdata = $urandom;
            lu_wdata   = $urandom;
            if (m_pend.size() > 0 && ($urandom % 3) == 0) begin
                lu_valid = 1'b1;
                lu_waddr = m_pend.pop_front();
            end else begin
                lu_valid = 1'b0;
                lu_waddr = 5'($urandom);
            end
            cycle($sformatf("rnd%0d", c));
        end

        // Mid-operation reset
        rst_n    = 1'b0;
        pipe_we  = 1'b1;
        lu_valid = 1'b1;
        #1 chk("mrst_rf_we_gated", o_rf_we, 0);
        cycle("mrst0");
        cycle("mrst1");
        idle();
        rst_n = 1'b1;
        #1;
        chk("mrst_rf_we", o_rf_we, 0);
        chk("mrst_busy", o_busy_vec, 0);
        chk("mrst_ready", o_lu_ready, 1);
        chk("mrst_hold", o_wb_hold, 0);
        chk("mrst_ovf", o_ovf_err, 0);
        for (int i = 0; i < 3; i++) cycle("mrst_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
